mips_regfile: RTL and testbench

MIPS_REGFILE -- requirements
Module: mips_regfile

---
 rtl/mips_regfile_if.sv | 22 ++
 rtl/mips_regfile.sv | 53 +++++
 tb/tb_mips_regfile.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_regfile_if.sv
// Bus bundle for mips_regfile. The master drives the write strobes, data and read addresses.
// The slave returns read data and status.
interface mips_regfile_if;
    logic [31:0] load;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        onehot_err;
    logic [15:0] wr_count;

    modport master (
        output load, wdata, raddr1, raddr2,
        input  rdata1, rdata2, onehot_err, wr_count
    );

    modport slave (
        input  load, wdata, raddr1, raddr2,
        output rdata1, rdata2, onehot_err, wr_count
    );
endinterface

// File: rtl/mips_regfile.sv
// MIPS register file: 31 x 32-bit registers plus a hardwired $zero, two combinational read ports.
// Optional write-to-read forwarding is enabled by defining MIPS_REGFILE_BYPASS_EN.
module mips_regfile (
    input  logic          clk,
    input  logic          rst,
    mips_regfile_if.slave bus
);
    logic [31:0] regs [1:31];
    logic [31:0] view [32];
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        err_q;
    logic [15:0] cnt_q;
    logic        multi_hot;
    logic        any_write;

    // Clearing the lowest set bit leaves a nonzero value exactly when two or more bits are set.
    assign multi_hot = (bus.load & (bus.load - 32'd1)) != 32'd0;
    assign any_write = |bus.load[31:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) regs[i] <= 32'd0;
            err_q <= 1'b0;
            cnt_q <= 16'd0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (bus.load[i]) regs[i] <= bus.wdata;
            end
            if (multi_hot) err_q <= 1'b1;
            if (any_write) cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        view[0] = 32'd0;
        for (int i = 1; i < 32; i++) view[i] = regs[i];
    end

    always_comb begin
        rd1 = view[bus.raddr1];
        rd2 = view[bus.raddr2];
`ifdef MIPS_REGFILE_BYPASS_EN
        if (!rst && bus.raddr1 != 5'd0 && bus.load[bus.raddr1]) rd1 = bus.wdata;
        if (!rst && bus.raddr2 != 5'd0 && bus.load[bus.raddr2]) rd2 = bus.wdata;
`endif
    end

    assign bus.rdata1     = rd1;
    assign bus.rdata2     = rd2;
    assign bus.onehot_err = err_q;
    assign bus.wr_count   = cnt_q;
endmodule

// File: tb/tb_mips_regfile.sv
// Randomized self-checking bench for mips_regfile against an array-based reference model.
module tb_mips_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mips_regfile_if bus_if ();

    mips_regfile dut (.clk(clk), .rst(rst), .bus(bus_if));

    always #5 clk = ~clk;

`ifdef MIPS_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [31:0] mem_m [32];
    logic [15:0] cnt_m;
    logic        err_m;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic r,
                                               input logic [31:0] ld, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (BYP && !r && ld[a]) return wd;
        return mem_m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
        cnt_m = 16'd0;
        err_m = 1'b0;
    endtask

    // One clock: apply inputs, check combinational reads and status before the edge, then advance the model.
    task automatic cycle(input logic r, input logic [31:0] ld, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst           = r;
        bus_if.load   = ld;
        bus_if.wdata  = wd;
        bus_if.raddr1 = a1;
        bus_if.raddr2 = a2;
        @(negedge clk);
        chk("rdata1", bus_if.rdata1, model_read(a1, r, ld, wd));
        chk("rdata2", bus_if.rdata2, model_read(a2, r, ld, wd));
        chk("onehot_err", {31'd0, bus_if.onehot_err}, {31'd0, err_m});
        chk("wr_count", {16'd0, bus_if.wr_count}, {16'd0, cnt_m});
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int i = 1; i < 32; i++) if (ld[i]) mem_m[i] = wd;
            if (ld[31:1] != 31'd0) cnt_m = cnt_m + 16'd1;
            if ($countones(ld) > 1) err_m = 1'b1;
        end
        #1;
    endtask

    initial begin
        logic [31:0] ld;
        bus_if.load   = 32'hFFFF_FFFF;
        bus_if.wdata  = 32'hFFFF_FFFF;
        bus_if.raddr1 = 5'd0;
        bus_if.raddr2 = 5'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // All addresses read zero after reset, on both ports.
        for (int a = 0; a < 32; a++) cycle(1'b0, 32'd0, 32'd0, a[4:0], 5'(31 - a));

        // Same-cycle read of a register being written, then next-cycle visibility.
        cycle(1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd8, 5'd8);
        cycle(1'b0, 32'd0, 32'd0, 5'd8, 5'd0);
        chk("reg8_after_write", bus_if.rdata1, 32'hDEAD_BEEF);
        chk("wr_count_one", {16'd0, bus_if.wr_count}, 32'd1);

        // load[0] never writes or counts, bypass or not.
        cycle(1'b0, 32'h0000_0001, 32'h1234_5678, 5'd0, 5'd0);
        cycle(1'b0, 32'd0, 32'd0, 5'd0, 5'd8);
        chk("zero_reg_after_load0", bus_if.rdata1, 32'd0);

        // A write during reset is dropped; reset clears everything.
        cycle(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 5'd2, 5'd8);
        cycle(1'b0, 32'd0, 32'd0, 5'd2, 5'd8);
        chk("reg2_after_rst_write", bus_if.rdata1, 32'd0);
        chk("wr_count_after_rst", {16'd0, bus_if.wr_count}, 32'd0);

        // Multi-hot write hits every selected register and sets the sticky flag.
        cycle(1'b0, 32'h8000_0002, 32'hA5A5_A5A5, 5'd1, 5'd31);
        cycle(1'b0, 32'd0, 32'd0, 5'd1, 5'd31);
        chk("reg1_multi", bus_if.rdata1, 32'hA5A5_A5A5);
        chk("reg31_multi", bus_if.rdata2, 32'hA5A5_A5A5);
        chk("onehot_err_set", {31'd0, bus_if.onehot_err}, 32'd1);
        cycle(1'b0, 32'h0000_0010, 32'h0BAD_F00D, 5'd4, 5'd31);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ld = 32'd1 << $urandom_range(0, 31);
                6:                ld = 32'd0;
                7:                ld = $urandom;
                8:                ld = 32'h0000_0001;
                default:          ld = $urandom;
            endcase
            cycle((n % 10 == 9) ? ($urandom_range(0, 3) == 0) : 1'b0, ld, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Drive wr_count up to 16'hFFFF, then one more write wraps it to zero.
        while (cnt_m != 16'hFFFF)
            cycle(1'b0, 32'd1 << $urandom_range(1, 31), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        cycle(1'b0, 32'h0000_0008, 32'h5555_AAAA, 5'd3, 5'd3);
        chk("wr_count_wrap", {16'd0, bus_if.wr_count}, 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 5'd3, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
